rv32i_mem_arbiter: RTL and testbench
====================================

Name: rv32i_mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the rv32i instruction-fetch port and data port, so the core can run from a unified memory.
- Per cycle, grants at most one requester, drives the RAM command, and routes the read data back to the owner using an in-flight tag pipeline.
- Data port has priority; a starvation counter forces an instruction grant after a bounded streak.
- A flush input drops stale fetch responses after a branch or jump redirect.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- ADDR_WIDTH, 32, byte address width; passed through unmodified.
- MEM_LAT, 1, RAM read latency in cycles from the m_en cycle to valid m_rdata; legal range 1..4.
- STARVE_MAX, 4, consecutive data grants allowed while i_req is pending; 0 means strict data priority with no forcing.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_req  in  1  fetch request
- i_addr  in  ADDR_WIDTH  fetch address
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_WIDTH  fetch data
- i_flush  in  1  discard all in-flight fetch responses
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_be  in  DATA_WIDTH/8  byte enables for writes
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_gnt  out  1  data request accepted (combinational)
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_WIDTH  load data
- m_en  out  1  RAM access strobe
- m_we  out  DATA_WIDTH/8  RAM byte write enables
- m_addr  out  ADDR_WIDTH  RAM address
- m_wdata  out  DATA_WIDTH  RAM write data
- m_rdata  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - All registered outputs go to 0: m_en, m_we, m_addr, m_wdata, i_rvalid, i_rdata, d_rvalid, d_rdata.
  - FSM goes to DPRI, starvation counter to 0, tag pipeline cleared.
  - Reset mid-operation discards all in-flight responses; no rvalid appears after reset deasserts.
- FSM has two states:
  - DPRI: d_req wins; otherwise i_req wins.
  - IFORCE: i_req wins unconditionally.
- Starvation counter:
  - Increments on each cycle with d_gnt=1 and i_req=1.
  - Clears on i_gnt or on i_req=0.
  - DPRI to IFORCE when the counter reaches STARVE_MAX (STARVE_MAX>0 only).
  - IFORCE to DPRI after one i_gnt, or when i_req=0.
- Grants:
  - i_gnt and d_gnt are combinational from the request inputs and the FSM state.
  - They are mutually exclusive.
  - A granted request is consumed in that same cycle.
- Command issue: a grant in cycle t sets m_en=1 at t+1, with m_addr, m_wdata and m_we registered.
  - m_we = d_be for a data write; 0 for reads and fetches.
  - m_en=0 in cycles with no grant.
- Tag pipeline: MEM_LAT+1 stages carrying {valid, is_instr, killed}.
  - A read arrives at t+1+MEM_LAT.
  - i_rvalid/d_rvalid and rdata are registered at t+2+MEM_LAT, so total latency is 3 cycles when MEM_LAT=1.
  - rdata holds its value when rvalid=0.
- Writes produce no rvalid.
- Back-to-back grants sustain one access per cycle; responses return in grant order.
- i_flush=1 in cycle f:
  - Sets killed on every fetch tag in flight, including a fetch granted in cycle f.
  - Those responses never assert i_rvalid.
  - Data responses are unaffected.
  - A fetch granted at f+1 or later is delivered normally.
- If i_req and d_req are both 0, nothing is granted and the counter clears.

Optional Feature:
- RV32I_ARB_PERF_EN defined:
  - Adds output ports perf_i_wait and perf_d_wait, each 32 bits.
  - Each counts cycles with req=1 and gnt=0 for its port.
  - Reset to 0; wrap at 2^32.
- Undefined: these ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Single fetch: i_req=1 at cycle 2 with i_addr=0x100 and m_rdata=0x00500093 → i_gnt at 2, m_en=1 with m_addr=0x100 at 3, i_rvalid=1 with i_rdata=0x00500093 at 5 (MEM_LAT=1).
- Byte store: d_req=1, d_we=1, d_be=4'b0001, d_addr=0x2000, d_wdata=0xAB → m_we=4'b0001 one cycle later; d_rvalid never asserts.
- Starvation with i_req and d_req held high for 12 cycles (STARVE_MAX=4) → grant sequence D D D D I D D D D I D D.
- Same stimulus with STARVE_MAX=0 → 12 consecutive data grants, i_gnt=0 throughout.
- Flush: fetches granted at cycles 10, 11, 12 with i_flush=1 at 11 → only the fetch granted at 12 produces i_rvalid, at cycle 15.
- Reset mid-flight: data read granted at cycle 20 with rst=1 at 21 → d_rvalid stays 0, all outputs 0 at 22, first new grant honored normally.

Source files
------------

// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between the rv32i fetch and data ports.
// Optional RV32I_ARB_PERF_EN adds per-port wait-cycle counters (perf_i_wait, perf_d_wait).
module rv32i_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_gnt,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    i_flush,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    m_en,
  output logic [DATA_WIDTH/8-1:0] m_we,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    state_o
`ifdef RV32I_ARB_PERF_EN
  ,
  output logic [31:0]             perf_i_wait,
  output logic [31:0]             perf_d_wait
`endif
);

  // Handshake: a request is accepted in the cycle its gnt is high; there is no
  // back-pressure on responses, rvalid is a single-cycle pulse per read.
  typedef enum logic {DPRI = 1'b0, IFORCE = 1'b1} state_e;

  typedef struct packed {
    logic valid;
    logic is_instr;
    logic killed;
  } tag_t;

  localparam int CW = $clog2(STARVE_MAX + 2);
  localparam logic [CW-1:0] STARVE_C = CW'(STARVE_MAX);

  state_e        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  tag_t          tag_q [MEM_LAT+1];
  tag_t          tag_new, tag_last;
  logic          i_deliver, d_deliver;

  assign state_o = state_q;

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (state_q == IFORCE) begin
      i_gnt = i_req;
      d_gnt = d_req & ~i_req;
    end else begin
      d_gnt = d_req;
      i_gnt = i_req & ~d_req;
    end
  end

  // Counter saturates at STARVE_MAX, so with STARVE_MAX=0 it never leaves zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_gnt || !i_req)
      cnt_d = '0;
    else if (d_gnt && cnt_q != STARVE_C)
      cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    tag_new          = '0;
    tag_new.valid    = i_gnt | (d_gnt & ~d_we);
    tag_new.is_instr = i_gnt;
    tag_new.killed   = i_gnt & i_flush;
  end

  // A flush in the cycle the oldest tag samples m_rdata still kills that fetch.
  assign tag_last  = tag_q[MEM_LAT];
  assign i_deliver = tag_last.valid & tag_last.is_instr & ~tag_last.killed & ~i_flush;
  assign d_deliver = tag_last.valid & ~tag_last.is_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DPRI;
      cnt_q    <= '0;
      m_en     <= 1'b0;
      m_we     <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      for (int k = 0; k <= MEM_LAT; k++) tag_q[k] <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        DPRI:    if (STARVE_MAX > 0 && i_req && cnt_d == STARVE_C) state_q <= IFORCE;
        IFORCE:  if (i_gnt || !i_req) state_q <= DPRI;
        default: state_q <= DPRI;
      endcase

      m_en <= i_gnt | d_gnt;
      m_we <= (d_gnt && d_we) ? d_be : '0;
      if (d_gnt) begin
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (i_gnt) begin
        m_addr  <= i_addr;
      end

      tag_q[0] <= tag_new;
      for (int k = 1; k <= MEM_LAT; k++) begin
        tag_q[k]        <= tag_q[k-1];
        tag_q[k].killed <= tag_q[k-1].killed | (tag_q[k-1].is_instr & i_flush);
      end

      i_rvalid <= i_deliver;
      d_rvalid <= d_deliver;
      if (i_deliver) i_rdata <= m_rdata;
      if (d_deliver) d_rdata <= m_rdata;
    end
  end

`ifdef RV32I_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_wait <= '0;
      perf_d_wait <= '0;
    end else begin
      if (i_req && !i_gnt) perf_i_wait <= perf_i_wait + 32'd1;
      if (d_req && !d_gnt) perf_d_wait <= perf_d_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: grant tables, starvation sequences and
// multi-cycle fetch/store/flush/reset sequences against a small RAM model.
module tb_rv32i_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_req = 0, i_flush = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0]  d_be = 0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, state;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_we;

  logic        i_gnt0, i_rvalid0, d_gnt0, d_rvalid0, m_en0, state0;
  logic [31:0] i_rdata0, d_rdata0, m_addr0, m_wdata0;
  logic [3:0]  m_we0;
`ifdef RV32I_ARB_PERF_EN
  logic [31:0] pi_w, pd_w, pi_w0, pd_w0;
`endif

  rv32i_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .i_flush(i_flush),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .state_o(state)
`ifdef RV32I_ARB_PERF_EN
    , .perf_i_wait(pi_w), .perf_d_wait(pd_w)
`endif
  );

  rv32i_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt0), .i_rvalid(i_rvalid0), .i_rdata(i_rdata0),
    .i_flush(i_flush),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
    .m_en(m_en0), .m_we(m_we0), .m_addr(m_addr0), .m_wdata(m_wdata0), .m_rdata(32'h0),
    .state_o(state0)
`ifdef RV32I_ARB_PERF_EN
    , .perf_i_wait(pi_w0), .perf_d_wait(pd_w0)
`endif
  );

  // ---------------- RAM model (1-cycle read latency) ----------------
  logic [31:0] mem [logic [31:0]];
  logic [31:0] mw;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (m_en) begin
      mw = mem.exists(m_addr) ? mem[m_addr] : dflt(m_addr);
      if (m_we != 4'b0) begin
        for (int b = 0; b < 4; b++) if (m_we[b]) mw[8*b +: 8] = m_wdata[8*b +: 8];
        mem[m_addr] = mw;
      end
      m_rdata <= mw;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_req = 0; d_req = 0; d_we = 0; i_flush = 0;
    repeat (n) tick();
  endtask

  // Scoreboard: {is_instr, data} in grant order
  logic [32:0] exp_q[$];
  logic [32:0] sb_e;
  bit          sb_en = 0;

  always @(negedge clk) begin
    if (sb_en && (i_rvalid || d_rvalid)) begin
      if (exp_q.size() == 0) chk("sb_spurious_rvalid", {i_rvalid, d_rvalid}, 2'b00);
      else begin
        sb_e = exp_q.pop_front();
        chk("sb_resp", {i_rvalid, i_rvalid ? i_rdata : d_rdata}, sb_e);
      end
    end
  end

  // ---------------- vector tables ----------------
  typedef struct {
    logic ir, dr;
    logic ei, ed;
  } gvec_t;

  typedef struct {
    logic ei4, ed4, ei0, ed0;
  } svec_t;

  gvec_t gv[7];
  svec_t sv[12];
  int    seen, at_k;
  logic [31:0] got_d;

  initial begin
    gv[0] = '{0, 0, 0, 0};
    gv[1] = '{1, 0, 1, 0};
    gv[2] = '{0, 0, 0, 0};
    gv[3] = '{0, 1, 0, 1};
    gv[4] = '{0, 0, 0, 0};
    gv[5] = '{1, 1, 0, 1};
    gv[6] = '{0, 0, 0, 0};
    for (int i = 0; i < 12; i++) sv[i] = '{0, 1, 0, 1};
    sv[4] = '{1, 0, 0, 1};
    sv[9] = '{1, 0, 0, 1};
    mem[32'h100] = 32'h0050_0093;

    // reset
    repeat (3) tick();
    rst = 0;
    settle();
    chk("rst_ctrl", {m_en, m_we, i_rvalid, d_rvalid}, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);

    // combinational grant table from idle DPRI
    i_addr = 32'h40; d_addr = 32'h44;
    for (int i = 0; i < 7; i++) begin
      tick();
      i_req = gv[i].ir; d_req = gv[i].dr;
      settle();
      chk($sformatf("gnt_vec%0d", i), {i_gnt, d_gnt}, {gv[i].ei, gv[i].ed});
    end
    idle(5);

    // single fetch: grant t, m_en t+1, i_rvalid t+3
    i_req = 1; i_addr = 32'h100;
    settle();
    chk("fetch_gnt", i_gnt, 1);
    tick(); i_req = 0; settle();
    chk("fetch_cmd", {m_en, m_we, m_addr}, {1'b1, 4'b0, 32'h100});
    tick(); settle();
    chk("fetch_early", i_rvalid, 0);
    tick(); settle();
    chk("fetch_resp", {i_rvalid, i_rdata}, {1'b1, 32'h0050_0093});
    tick(); settle();
    chk("fetch_hold", {i_rvalid, i_rdata}, {1'b0, 32'h0050_0093});
    idle(3);

    // byte store, then read back
    d_req = 1; d_we = 1; d_be = 4'b0001; d_addr = 32'h2000; d_wdata = 32'hAB;
    settle();
    chk("store_gnt", d_gnt, 1);
    tick(); d_req = 0; d_we = 0; settle();
    chk("store_cmd", {m_en, m_we, m_addr}, {1'b1, 4'b0001, 32'h2000});
    chk("store_wdata", m_wdata, 32'hAB);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick(); settle();
      if (d_rvalid) seen++;
    end
    chk("store_no_rvalid", seen, 0);
    tick(); d_req = 1; d_addr = 32'h2000; settle();
    tick(); d_req = 0; settle();
    tick(); settle();
    tick(); settle();
    chk("store_readback", {d_rvalid, d_rdata}, {1'b1, 32'hDFFF_20AB});
    idle(4);

    // starvation table, responses tracked by the scoreboard
    sb_en = 1;
    i_addr = 32'h400; d_addr = 32'h3000;
    for (int i = 0; i < 12; i++) begin
      i_req = 1; d_req = 1;
      settle();
      chk($sformatf("starve4_%0d", i), {i_gnt, d_gnt}, {sv[i].ei4, sv[i].ed4});
      chk($sformatf("starve0_%0d", i), {i_gnt0, d_gnt0}, {sv[i].ei0, sv[i].ed0});
      exp_q.push_back(sv[i].ei4 ? {1'b1, dflt(32'h400)} : {1'b0, dflt(32'h3000)});
      tick();
    end
    i_req = 0; d_req = 0;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
    settle();
    chk("sb_drained", exp_q.size(), 0);
    sb_en = 0;
    idle(3);

    // flush: fetches at F0..F2, flush at F1; only F2 returns, at F5
    i_req = 1; i_addr = 32'h500;
    settle();
    chk("flush_gnt0", i_gnt, 1);
    tick(); i_addr = 32'h504; i_flush = 1; settle();
    tick(); i_addr = 32'h508; i_flush = 0; settle();
    chk("flush_gnt2", i_gnt, 1);
    tick(); i_req = 0;
    seen = 0; at_k = -1; got_d = 0;
    for (int k = 3; k < 9; k++) begin
      settle();
      if (i_rvalid) begin seen++; at_k = k; got_d = i_rdata; end
      tick();
    end
    chk("flush_count", seen, 1);
    chk("flush_cycle", at_k, 5);
    chk("flush_data", got_d, 32'hFAF7_0508);
    idle(2);

    // reset while a data read is in flight
    d_req = 1; d_we = 0; d_addr = 32'h3000;
    settle();
    chk("rmid_gnt", d_gnt, 1);
    tick(); d_req = 0; rst = 1; settle();
    tick(); rst = 0; settle();
    chk("rmid_ctrl", {m_en, m_we, i_rvalid, d_rvalid}, 0);
    chk("rmid_m", {m_addr, m_wdata}, 0);
    chk("rmid_rdata", {i_rdata, d_rdata}, 0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); settle();
      if (d_rvalid || i_rvalid) seen++;
    end
    chk("rmid_no_rvalid", seen, 0);
    tick(); d_req = 1; settle();
    chk("rmid_new_gnt", d_gnt, 1);
    tick(); d_req = 0; settle();
    tick(); settle();
    tick(); settle();
    chk("rmid_new_resp", {d_rvalid, d_rdata}, {1'b1, 32'hCFFF_3000});
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
